// File: rtl/cond_exec_ctrl.sv
// cond_exec_ctrl: E-stage NZCV flags, condition gating and post-branch squash; FULL_COND_EN enables all 15 conditions.
module cond_exec_ctrl #(
  parameter int SQUASH_CYCLES = 2,
  parameter int CNT_W = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       valid_e,
  input  logic       stall_e,
  input  logic [3:0] cond_e,
  input  logic [1:0] flag_write_e,
  input  logic [3:0] alu_flags,
  input  logic       reg_write_e,
  input  logic       mem_write_e,
  input  logic       pc_src_e,
  output logic [3:0] flags,
  output logic       cond_ex,
  output logic       reg_write_g,
  output logic       mem_write_g,
  output logic       pc_src_g,
  output logic       flush_fd,
  output logic       undef_cond
);
  typedef enum logic {RUN, SQUASH} state_t;
  state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0] flags_q, flags_d;
  logic cond_true, unsup, pass;
  always_comb begin
    cond_true = 1'b0;
    unsup = 1'b0;
    case (cond_e)
      4'h0: cond_true = flags_q[2];
      4'h1: cond_true = ~flags_q[2];
`ifdef FULL_COND_EN
      4'h2: cond_true = flags_q[1];
      4'h3: cond_true = ~flags_q[1];
      4'h4: cond_true = flags_q[3];
      4'h5: cond_true = ~flags_q[3];
      4'h6: cond_true = flags_q[0];
      4'h7: cond_true = ~flags_q[0];
      4'h8: cond_true = flags_q[1] & ~flags_q[2];
      4'h9: cond_true = ~(flags_q[1] & ~flags_q[2]);
      4'ha: cond_true = flags_q[3] == flags_q[0];
      4'hb: cond_true = flags_q[3] != flags_q[0];
      4'hc: cond_true = ~flags_q[2] & (flags_q[3] == flags_q[0]);
      4'hd: cond_true = ~(~flags_q[2] & (flags_q[3] == flags_q[0]));
`endif
      4'he: cond_true = 1'b1;
      default: unsup = 1'b1;
    endcase
  end
  assign pass        = valid_e & ~stall_e & cond_true & (state_q == RUN);
  assign cond_ex     = pass;
  assign reg_write_g = pass & reg_write_e;
  assign mem_write_g = pass & mem_write_e;
  assign pc_src_g    = pass & pc_src_e;
  assign flush_fd    = pc_src_g;
  assign undef_cond  = valid_e & unsup;
  assign flags       = flags_q;
  always_comb begin
    flags_d = flags_q;
    state_d = state_q;
    cnt_d = cnt_q;
    if (pass) begin
      flags_d[3:2] = flag_write_e[1] ? alu_flags[3:2] : flags_q[3:2];
      flags_d[1:0] = flag_write_e[0] ? alu_flags[1:0] : flags_q[1:0];
    end
    // only real, unstalled slots consume squash obligations
    if (state_q == RUN && pc_src_g) begin
      state_d = SQUASH;
      cnt_d = CNT_W'(SQUASH_CYCLES);
    end else if (state_q == SQUASH && valid_e && !stall_e) begin
      cnt_d = cnt_q - 1'b1;
      state_d = (cnt_q == CNT_W'(1)) ? RUN : SQUASH;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q <= '0;
      state_q <= RUN;
      cnt_q <= '0;
    end else begin
      flags_q <= flags_d;
      state_q <= state_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: tb/tb_cond_exec_ctrl.sv
// tb_cond_exec_ctrl: directed vectors with a queued scoreboard checked by a negedge monitor.
module tb_cond_exec_ctrl;
`ifdef FULL_COND_EN
  localparam bit FULL = 1'b1;
`else
  localparam bit FULL = 1'b0;
`endif
  typedef struct {
    string nm;
    logic [9:0] ex;
  } exp_t;
  logic clk = 1'b0, rst_n = 1'b0;
  logic valid_e = 1'b0, stall_e = 1'b0, reg_write_e = 1'b0, mem_write_e = 1'b0, pc_src_e = 1'b0;
  logic [3:0] cond_e = 4'h0, alu_flags = 4'h0;
  logic [1:0] flag_write_e = 2'b00;
  logic [3:0] flags;
  logic cond_ex, reg_write_g, mem_write_g, pc_src_g, flush_fd, undef_cond;
  exp_t q[$];
  int n_chk = 0, n_fail = 0;
  cond_exec_ctrl #(.SQUASH_CYCLES(2), .CNT_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .valid_e(valid_e), .stall_e(stall_e), .cond_e(cond_e),
    .flag_write_e(flag_write_e), .alu_flags(alu_flags), .reg_write_e(reg_write_e),
    .mem_write_e(mem_write_e), .pc_src_e(pc_src_e), .flags(flags), .cond_ex(cond_ex),
    .reg_write_g(reg_write_g), .mem_write_g(mem_write_g), .pc_src_g(pc_src_g),
    .flush_fd(flush_fd), .undef_cond(undef_cond)
  );
  always #5 clk = ~clk;
  function automatic logic [9:0] outs();
    return {flags, cond_ex, reg_write_g, mem_write_g, pc_src_g, flush_fd, undef_cond};
  endfunction
  task automatic chk(input string nm, input logic [9:0] act, input logic [9:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got flags/ce/rw/mw/pc/fd/ud=%b required %b", nm, act, exp);
    end
  endtask
  // expected = {flags, cond_ex, reg_write_g, mem_write_g, pc_src_g, flush_fd, undef_cond}
  task automatic vec(input string nm, input logic v, input logic st, input logic [3:0] c,
                     input logic [1:0] fw, input logic [3:0] alu, input logic rw, input logic mw,
                     input logic pc, input logic [3:0] efl, input logic ece, input logic erw,
                     input logic emw, input logic epc, input logic eud);
    exp_t e;
    valid_e = v; stall_e = st; cond_e = c; flag_write_e = fw; alu_flags = alu;
    reg_write_e = rw; mem_write_e = mw; pc_src_e = pc;
    e.nm = nm;
    e.ex = {efl, ece, erw, emw, epc, epc, eud};
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk(e.nm, outs(), e.ex);
      end
    end
  end
  initial begin : stim
    #1 chk("reset", outs(), 10'b0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    vec("al_rw",   1, 0, 4'he, 2'b00, 4'h0, 1, 0, 0, 4'b0000, 1, 1, 0, 0, 0);
    vec("cmp",     1, 0, 4'he, 2'b11, 4'h4, 0, 0, 0, 4'b0000, 1, 0, 0, 0, 0);
    vec("eq_mw",   1, 0, 4'h0, 2'b00, 4'h0, 0, 1, 0, 4'b0100, 1, 0, 1, 0, 0);
    vec("ne_mw",   1, 0, 4'h1, 2'b11, 4'hf, 0, 1, 0, 4'b0100, 0, 0, 0, 0, 0);
    vec("set1011", 1, 0, 4'he, 2'b11, 4'hb, 0, 0, 0, 4'b0100, 1, 0, 0, 0, 0);
    vec("part_nz", 1, 0, 4'he, 2'b10, 4'h4, 0, 0, 0, 4'b1011, 1, 0, 0, 0, 0);
    vec("ge_fail", 1, 0, 4'ha, 2'b11, 4'hf, 0, 0, 0, 4'b0111, 0, 0, 0, 0, !FULL);
    vec("lt",      1, 0, 4'hb, 2'b00, 4'h0, 1, 0, 0, 4'b0111, FULL, FULL, 0, 0, !FULL);
    vec("rsv",     1, 0, 4'hf, 2'b11, 4'hf, 1, 1, 1, 4'b0111, 0, 0, 0, 0, 1);
    vec("branch",  1, 0, 4'he, 2'b00, 4'h0, 0, 0, 1, 4'b0111, 1, 0, 0, 1, 0);
    vec("sq1",     1, 0, 4'he, 2'b11, 4'hf, 1, 1, 1, 4'b0111, 0, 0, 0, 0, 0);
    vec("bubble",  0, 0, 4'he, 2'b00, 4'h0, 1, 0, 0, 4'b0111, 0, 0, 0, 0, 0);
    vec("sq_stall",1, 1, 4'he, 2'b00, 4'h0, 1, 0, 0, 4'b0111, 0, 0, 0, 0, 0);
    vec("sq2",     1, 0, 4'he, 2'b11, 4'hf, 1, 0, 0, 4'b0111, 0, 0, 0, 0, 0);
    vec("post_sq", 1, 0, 4'he, 2'b00, 4'h0, 1, 0, 0, 4'b0111, 1, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++)
      vec("eq_stall", 1, 1, 4'h0, 2'b11, 4'h9, 1, 1, 0, 4'b0111, 0, 0, 0, 0, 0);
    vec("eq_go",   1, 0, 4'h0, 2'b11, 4'h9, 1, 1, 0, 4'b0111, 1, 1, 1, 0, 0);
    vec("fl1001",  0, 0, 4'h0, 2'b00, 4'h0, 0, 0, 0, 4'b1001, 0, 0, 0, 0, 0);
    vec("ge_nv",   1, 0, 4'ha, 2'b00, 4'h0, 0, 1, 0, 4'b1001, FULL, 0, FULL, 0, !FULL);
    vec("branch2", 1, 0, 4'he, 2'b00, 4'h0, 0, 0, 1, 4'b1001, 1, 0, 0, 1, 0);
    valid_e = 1'b0; pc_src_e = 1'b0; mem_write_e = 1'b0; reg_write_e = 1'b0;
    #2 rst_n = 1'b0;
    #1 chk("rst_mid_sq", outs(), 10'b0);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    vec("after_rst", 1, 0, 4'he, 2'b00, 4'h0, 1, 0, 0, 4'b0000, 1, 1, 0, 0, 0);
    vec("idle",      0, 0, 4'he, 2'b00, 4'h0, 0, 0, 0, 4'b0000, 0, 0, 0, 0, 0);
    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    #1;
    if (q.size() != 0) chk("drain_timeout", 10'(q.size()), 10'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
